prescaled_counter: RTL and testbench



---
 rtl/prescaled_counter.sv | 145 ++++++++++++++
 tb/tb_prescaled_counter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prescaled_counter.sv
// prescaled_counter
//
// An N-bit prescaler divides clk. Every prescaler overflow steps a W-bit
// counter in up, down, bounce or hold mode. The counter runs modulo MAX+1
// and can be loaded synchronously (the load value is clamped to MAX).
// tick marks every step opportunity; wrap marks a wrap or a bounce reversal.
//
// Ports:
//   clk       in   system clock, rising edge
//   rstn      in   asynchronous active-low reset
//   en        in   prescaler enable; low freezes the prescaler
//   mode      in   2'b00 up, 2'b01 down, 2'b10 bounce, 2'b11 hold
//   load      in   synchronous load strobe, wins over a step
//   load_val  in   value for load (clamped to MAX)
//   count     out  current count (registered)
//   dir       out  current direction, 1 = up, 0 = down (registered)
//   tick      out  one-cycle pulse on every step edge (registered)
//   wrap      out  one-cycle pulse on a wrap or bounce reversal (registered)
//
// There is no handshake: every input is sampled on each rising clk edge and
// every output is a plain register, so no input reaches an output without a
// clock edge in between.

module prescaled_counter #(
  parameter int          N   = 20,
  parameter int          W   = 8,
  parameter int unsigned MAX = (1 << W) - 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic [1:0]   mode,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         dir,
  output logic         tick,
  output logic         wrap
);

  localparam logic [W-1:0] MAX_C = MAX[W-1:0];

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  mode_e        mode_s;
  logic [N-1:0] presc;
  logic         step;
  logic [W-1:0] step_count;
  logic         step_dir;
  logic         step_wrap;
  logic [W-1:0] load_count;

  assign mode_s = mode_e'(mode);

  // A step happens on the edge where the prescaler is about to roll over.
  assign step = en & (&presc);

  // Values the counter takes if this edge turns out to be a step edge.
  always_comb begin
    step_count = count;
    step_dir   = dir;
    step_wrap  = 1'b0;
    case (mode_s)
      MODE_UP: begin
        step_dir = 1'b1;
        if (count == MAX_C) begin
          step_count = '0;
          step_wrap  = 1'b1;
        end else begin
          step_count = count + 1'b1;
        end
      end
      MODE_DOWN: begin
        step_dir = 1'b0;
        if (count == '0) begin
          step_count = MAX_C;
          step_wrap  = 1'b1;
        end else begin
          step_count = count - 1'b1;
        end
      end
      MODE_BOUNCE: begin
        if (dir) begin
          // >= rather than == so a count at the top always turns around.
          if (count >= MAX_C) begin
            step_count = MAX_C - 1'b1;
            step_dir   = 1'b0;
            step_wrap  = 1'b1;
          end else begin
            step_count = count + 1'b1;
          end
        end else begin
          if (count == '0) begin
            step_count = W'(1);
            step_dir   = 1'b1;
            step_wrap  = 1'b1;
          end else begin
            step_count = count - 1'b1;
          end
        end
      end
      default: begin
        // Hold: count and direction stay put, tick still pulses.
        step_count = count;
        step_dir   = dir;
        step_wrap  = 1'b0;
      end
    endcase
  end

  assign load_count = (load_val > MAX_C) ? MAX_C : load_val;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc <= '0;
      count <= '0;
      dir   <= 1'b1;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else if (load) begin
      // Load restarts the step period; direction is kept.
      count <= load_count;
      presc <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      tick <= step;
      wrap <= step & step_wrap;
      if (en) begin
        // Rolls from all-ones to zero naturally on the step edge.
        presc <= presc + 1'b1;
      end
      if (step) begin
        count <= step_count;
        dir   <= step_dir;
      end
    end
  end

endmodule

// File: tb/tb_prescaled_counter.sv
module tb_prescaled_counter;

  localparam int N      = 2;
  localparam int W      = 4;
  localparam int MAX    = 9;
  localparam int PERIOD = 1 << N;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rstn;
  logic         en;
  logic [1:0]   mode;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         dir;
  logic         tick;
  logic         wrap;

  // second instance: default W and MAX, short prescaler
  logic         en8;
  logic [1:0]   mode8;
  logic         load8;
  logic [7:0]   load_val8;
  logic [7:0]   count8;
  logic         dir8;
  logic         tick8;
  logic         wrap8;

  always #5 clk = ~clk;

  prescaled_counter #(.N(N), .W(W), .MAX(MAX)) dut (
    .clk(clk), .rstn(rstn), .en(en), .mode(mode), .load(load),
    .load_val(load_val), .count(count), .dir(dir), .tick(tick), .wrap(wrap)
  );

  prescaled_counter #(.N(2)) dut8 (
    .clk(clk), .rstn(rstn), .en(en8), .mode(mode8), .load(load8),
    .load_val(load_val8), .count(count8), .dir(dir8), .tick(tick8), .wrap(wrap8)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [W+2:0] exp_q[$];

  task automatic check(input string name, input int ac, input bit ad, input bit at,
                       input bit aw, input int ec, input bit ed, input bit et, input bit ew);
    n_vec++;
    if (ac != ec || ad != ed || at != et || aw != ew) begin
      n_err++;
      $display("FAIL %s: got count=%0d dir=%0b tick=%0b wrap=%0b, expected count=%0d dir=%0b tick=%0b wrap=%0b",
               name, ac, ad, at, aw, ec, ed, et, ew);
    end
  endtask

  task automatic check_int(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // ---------------- reference model ----------------
  // Up/down are modulo arithmetic; bounce walks a phase around a ring of
  // length 2*MAX (phase p < MAX+1 means count = p going up, otherwise
  // count = 2*MAX - p going down). A reversal is a change of direction.
  int m_presc, m_count;
  bit m_dir, m_tick, m_wrap;

  task automatic model_reset();
    m_presc = 0; m_count = 0; m_dir = 1; m_tick = 0; m_wrap = 0;
  endtask

  task automatic model_step(input bit [1:0] md);
    int p;
    bit nd;
    case (md)
      2'd0: begin
        m_wrap  = (m_count == MAX);
        m_count = (m_count + 1) % (MAX + 1);
        m_dir   = 1;
      end
      2'd1: begin
        m_wrap  = (m_count == 0);
        m_count = (m_count + MAX) % (MAX + 1);
        m_dir   = 0;
      end
      2'd2: begin
        p  = m_dir ? m_count : (2 * MAX - m_count) % (2 * MAX);
        p  = (p + 1) % (2 * MAX);
        nd = (p >= 1 && p <= MAX);
        m_count = (p <= MAX) ? p : 2 * MAX - p;
        m_wrap  = (nd != m_dir);
        m_dir   = nd;
      end
      default: m_wrap = 0;
    endcase
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input bit e, input bit [1:0] md, input bit ld,
                             input int lv, input string name);
    logic [W+2:0] ex;
    en = e; mode = md; load = ld; load_val = W'(lv);
    m_tick = 0; m_wrap = 0;
    if (ld) begin
      m_count = (lv > MAX) ? MAX : lv;
      m_presc = 0;
    end else if (e) begin
      if (m_presc == PERIOD - 1) begin
        m_presc = 0;
        m_tick  = 1;
        model_step(md);
      end else begin
        m_presc++;
      end
    end
    exp_q.push_back({W'(m_count), m_dir, m_tick, m_wrap});
    @(posedge clk);
    #1;
    ex = exp_q.pop_front();
    check(name, count, dir, tick, wrap, ex[W+2:3], ex[2], ex[1], ex[0]);
  endtask

  task automatic drive8(input bit e, input bit [1:0] md, input bit ld, input int lv,
                        input int ncyc, input int ec, input bit ed, input bit et,
                        input bit ew, input string name);
    for (int k = 0; k < ncyc; k++) begin
      en8 = e; mode8 = md; load8 = ld; load_val8 = 8'(lv);
      @(posedge clk);
      #1;
    end
    en8 = 0; load8 = 0;
    check(name, count8, dir8, tick8, wrap8, ec, ed, et, ew);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit       en;
    bit [1:0] mode;
    bit       load;
    int       val;
    int       ncyc;
    int       c;
    bit       d;
    bit       t;
    bit       w;
  } vec_t;

  vec_t tbl[21];

  initial begin
    int ticks, wraps;
    bit e, ld;

    tbl[0]  = '{1, 2'd2, 1, 7,  1,  7, 1, 0, 0}; // load 7, bounce
    tbl[1]  = '{1, 2'd2, 0, 0,  4,  8, 1, 1, 0};
    tbl[2]  = '{1, 2'd2, 0, 0,  4,  9, 1, 1, 0};
    tbl[3]  = '{1, 2'd2, 0, 0,  4,  8, 0, 1, 1}; // reversal at top
    tbl[4]  = '{1, 2'd2, 0, 0,  3,  8, 0, 0, 0}; // mid-period
    tbl[5]  = '{0, 2'd2, 0, 0, 10,  8, 0, 0, 0}; // en low: frozen
    tbl[6]  = '{1, 2'd2, 0, 0,  1,  7, 0, 1, 0}; // period resumes
    tbl[7]  = '{1, 2'd1, 1, 1,  1,  1, 0, 0, 0}; // load 1, down
    tbl[8]  = '{1, 2'd1, 0, 0,  4,  0, 0, 1, 0};
    tbl[9]  = '{1, 2'd1, 0, 0,  4,  9, 0, 1, 1}; // 0 -> 9 wrap
    tbl[10] = '{1, 2'd1, 0, 0,  4,  8, 0, 1, 0};
    tbl[11] = '{1, 2'd2, 1, 1,  1,  1, 0, 0, 0}; // bounce going down
    tbl[12] = '{1, 2'd2, 0, 0,  4,  0, 0, 1, 0};
    tbl[13] = '{1, 2'd2, 0, 0,  4,  1, 1, 1, 1}; // reversal at bottom
    tbl[14] = '{1, 2'd3, 0, 0,  4,  1, 1, 1, 0}; // hold: tick only
    tbl[15] = '{1, 2'd3, 0, 0,  4,  1, 1, 1, 0};
    tbl[16] = '{1, 2'd0, 0, 0,  3,  1, 1, 0, 0};
    tbl[17] = '{1, 2'd0, 1, 15, 1,  9, 1, 0, 0}; // clamp, load beats step
    tbl[18] = '{1, 2'd0, 0, 0,  3,  9, 1, 0, 0};
    tbl[19] = '{1, 2'd0, 0, 0,  1,  0, 1, 1, 1}; // 9 -> 0 wrap
    tbl[20] = '{1, 2'd0, 0, 0,  4,  1, 1, 1, 0};

    en = 0; mode = 0; load = 0; load_val = 0;
    en8 = 0; mode8 = 0; load8 = 0; load_val8 = 0;
    rstn = 1;
    #1 rstn = 0;
    #1;
    check("reset_init", count, dir, tick, wrap, 0, 1, 0, 0);
    check("reset_init8", count8, dir8, tick8, wrap8, 0, 1, 0, 0);
    @(posedge clk);
    #1 rstn = 1;
    model_reset();

    // reset/up run
    ticks = 0; wraps = 0;
    for (int i = 0; i < 48; i++) begin
      drive_cycle(1, 2'd0, 0, 0, "up_run");
      ticks += int'(tick);
      wraps += int'(wrap);
    end
    check_int("up_ticks", ticks, 12);
    check_int("up_wraps", wraps, 1);
    check_int("up_final", int'(count), 2);

    // directed table
    for (int i = 0; i < 21; i++) begin
      for (int k = 0; k < tbl[i].ncyc; k++)
        drive_cycle(tbl[i].en, tbl[i].mode, tbl[i].load, tbl[i].val, "table_model");
      check($sformatf("table[%0d]", i), count, dir, tick, wrap,
            tbl[i].c, tbl[i].d, tbl[i].t, tbl[i].w);
    end

    // async reset between edges while count = 5
    drive_cycle(0, 2'd3, 1, 5, "pre_reset");
    check_int("pre_reset_count", int'(count), 5);
    #2 rstn = 0;
    #1;
    check("async_reset", count, dir, tick, wrap, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    check("reset_held", count, dir, tick, wrap, 0, 1, 0, 0);
    rstn = 1;
    model_reset();

    // randomized run against the model
    for (int i = 0; i < 800; i++) begin
      e  = ($urandom_range(0, 3) != 0);
      ld = ($urandom_range(0, 15) == 0);
      drive_cycle(e, 2'($urandom_range(0, 3)), ld, $urandom_range(0, 15), "random");
    end

    // default W/MAX instance: 255 -> 0 wrap
    drive8(1, 2'd0, 1, 254, 1, 254, 1, 0, 0, "w8_load");
    drive8(1, 2'd0, 0, 0,   4, 255, 1, 1, 0, "w8_up_top");
    drive8(1, 2'd0, 0, 0,   4, 0,   1, 1, 1, "w8_wrap");
    drive8(1, 2'd1, 0, 0,   4, 255, 0, 1, 1, "w8_down_wrap");
    drive8(1, 2'd2, 0, 0,   4, 254, 0, 1, 0, "w8_bounce");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
